apb_master_arbiter: RTL

Round-robin arbiter that shares the single APB master control interface among `NUM_REQ` requesters (CPU bridge, DMA, debug port, …). It sits between the requesters and the APB master's valid/ready request port. It grants one requester at a time and issues that request to the master. It watches the APB bus for transfer completion and returns the done, error and read-data response to the requester that owns the transfer. It allows one outstanding transfer at a time.

---
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master request port among NUM_REQ requesters.
// One transfer is outstanding at a time; its completion, error and read data go back to its owner.
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input  logic                             i_clk_apb,
  input  logic                             i_rstn_apb,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*addr_width-1:0]    i_req_addr,
  input  logic [NUM_REQ-1:0]               i_req_rd0_wr1,
  input  logic [NUM_REQ*data_width-1:0]    i_req_wr_data,
  output logic [NUM_REQ-1:0]               o_req_done,
  output logic [NUM_REQ-1:0]               o_req_err,
  output logic [NUM_REQ-1:0]               o_req_rd_valid,
  output logic [data_width-1:0]            o_req_rd_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [addr_width-1:0]            o_addr,
  output logic                             o_rd0_wr1,
  output logic [data_width-1:0]            o_wr_data,
  input  logic [data_width-1:0]            i_rd_data,
  input  logic                             i_psel,
  input  logic                             i_penable,
  input  logic                             i_pready,
  input  logic                             i_pslverr,
  output logic                             o_busy,
  output logic [$clog2(NUM_REQ)-1:0]       o_grant_id
);
  // state | meaning
  // IDLE  | arbitrating; a grant pulses o_req_ready and latches the winner's fields
  // ISSUE | o_valid held with stable fields until the master accepts
  // WAIT  | waiting for the APB ACCESS beat with pready to close the transfer
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [NUM_REQ-1:0]    rdv_q, rdv_d;

  logic                  win_found;
  logic [GW-1:0]         win_id;
  logic [GW-1:0]         cand;
  logic                  apb_done;

  assign apb_done = i_psel & i_penable & i_pready;

  // Search starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    done_d      = '0;
    err_d       = '0;
    rdv_d       = '0;
    o_req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          o_req_ready[win_id] = 1'b1;
          last_d  = win_id;
          grant_d = win_id;
          addr_d  = i_req_addr[int'(win_id)*addr_width +: addr_width];
          wr_d    = i_req_rd0_wr1[win_id];
          wdata_d = i_req_wr_data[int'(win_id)*data_width +: data_width];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_ready) state_d = S_WAIT;
        else         valid_d = 1'b1;
      end
      S_WAIT: begin
        if (apb_done) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = i_pslverr;
          if (!wr_q) begin
            rdv_d[grant_q] = 1'b1;
            rdata_d        = i_rd_data;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk_apb) begin
    if (!i_rstn_apb) begin
      state_q <= S_IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      rdv_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_addr         = addr_q;
  assign o_rd0_wr1      = wr_q;
  assign o_wr_data      = wdata_q;
  assign o_busy         = busy_q;
  assign o_grant_id     = grant_q;
  assign o_req_done     = done_q;
  assign o_req_err      = err_q;
  assign o_req_rd_valid = rdv_q;
  assign o_req_rd_data  = rdata_q;

endmodule
